instr_decode_stage: RTL and testbench

- Parametrised, pipelined successor to the single-format instruction decoder.
- Takes instruction words from the block's instruction memory over a valid/ready handshake and decodes both instruction formats at configurable field widths.
- Detects register read-after-write hazards against a fixed-latency execute pipeline and holds issue until they clear.
- Delivers one registered decoded bundle per cycle to the block execute unit.

---
 rtl/instr_dec_pkg.sv | 57 +++++
 rtl/hazard_scoreboard.sv | 54 +++++
 rtl/instr_decode_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dec_pkg.sv
// instr_dec_pkg
//   Shared definitions for the instruction decode stage: opcode encoding,
//   the zero-extended opcode type the helper functions operate on, and the
//   per-opcode classification functions (operand use, destination write,
//   defined-opcode test).
//   Opcodes are densely encoded from 0 to NUM_OPS-1. Any value at or above
//   NUM_OPS is undefined.
//   Optional feature macro used by the importing stage:
//   INSTR_DEC_ILLEGAL_TRAP_EN.
package instr_dec_pkg;

  localparam int unsigned OP_EXT_W = 8;
  localparam int unsigned NUM_OPS  = 16;

  typedef logic [OP_EXT_W-1:0] op_ext_t;

  typedef enum op_ext_t {
    OP_NOP        = 8'd0,
    OP_LOAD       = 8'd1,
    OP_MOV_ACC    = 8'd2,
    OP_FRAC_DELAY = 8'd3,
    OP_LOAD_ACC   = 8'd4,
    OP_SAVE_ACC   = 8'd5,
    OP_CLEAR_ACC  = 8'd6,
    OP_MOV_UACC   = 8'd7,
    OP_ADD        = 8'd8,
    OP_SUB        = 8'd9,
    OP_MUL        = 8'd10,
    OP_MADD       = 8'd11,
    OP_CLAMP      = 8'd12,
    OP_MACZ       = 8'd13,
    OP_MAC        = 8'd14,
    OP_LINTERP    = 8'd15
  } opcode_e;

  // Returns {c_needed, b_needed, a_needed}.
  function automatic logic [2:0] src_needed(input op_ext_t op);
    logic a_n;
    logic b_n;
    logic c_n;
    a_n = !(op inside {OP_NOP, OP_LOAD, OP_MOV_ACC, OP_FRAC_DELAY,
                       OP_LOAD_ACC, OP_SAVE_ACC, OP_CLEAR_ACC, OP_MOV_UACC});
    b_n = op inside {OP_ADD, OP_SUB, OP_MUL, OP_MADD, OP_CLAMP,
                     OP_MACZ, OP_MAC, OP_LINTERP};
    c_n = op inside {OP_MADD, OP_CLAMP, OP_MACZ, OP_MAC, OP_LINTERP};
    return {c_n, b_n, a_n};
  endfunction

  function automatic logic writes_dest(input op_ext_t op);
    return !(op inside {OP_NOP, OP_SAVE_ACC, OP_CLEAR_ACC});
  endfunction

  function automatic logic is_defined_op(input op_ext_t op);
    return op < op_ext_t'(NUM_OPS);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks destinations of instructions in flight through a fixed-latency
//   execute pipeline. One {valid, addr} entry per cycle of latency; the
//   whole register shifts every cycle, so an entry falls off the end
//   HAZARD_DEPTH cycles after it was inserted.
// Ports:
//   clk, reset       clock, synchronous active-high reset (clears entries)
//   i_insert         load entry 0 valid this cycle (else entry 0 invalid)
//   i_insert_addr    destination address for the new entry
//   i_src_addr[3]    source addresses to compare (a, b, c)
//   i_src_check[3]   per-source enable for the comparison
//   o_match[3]       source matches any valid entry
module hazard_scoreboard #(
  parameter int unsigned HAZARD_DEPTH   = 3,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_insert,
  input  logic [REG_ADDR_WIDTH-1:0]      i_insert_addr,
  input  logic [2:0][REG_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [2:0]                     i_src_check,
  output logic [2:0]                     o_match
);

  logic [HAZARD_DEPTH-1:0]                     r_valid;
  logic [HAZARD_DEPTH-1:0][REG_ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      for (int unsigned k = 1; k < HAZARD_DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
      r_valid[0] <= i_insert;
      r_addr[0]  <= i_insert_addr;
    end
  end

  always_comb begin
    o_match = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      for (int unsigned k = 0; k < HAZARD_DEPTH; k++) begin
        if (i_src_check[s] && r_valid[k] && (r_addr[k] == i_src_addr[s])) begin
          o_match[s] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Pipelined instruction decoder. Accepts instruction words over a
//   valid/ready handshake, decodes format 0 and format 1 at parameterised
//   field widths, holds issue while a needed register source is still being
//   produced by the execute pipeline, and presents one registered decoded
//   bundle per cycle.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_instr/in_valid      instruction word and its valid
//   in_ready               stage takes in_instr this cycle
//   out_valid/out_ready    decoded bundle handshake to the execute unit
//   out_op .. out_res_addr decoded bundle fields
//   stall                  register hazard is holding issue this cycle
//   illegal                (INSTR_DEC_ILLEGAL_TRAP_EN only) bundle was
//                          illegal and has been replaced by NOP
// Optional feature macro: INSTR_DEC_ILLEGAL_TRAP_EN
module instr_decode_stage
  import instr_dec_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned OP_WIDTH       = 5,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned SHIFT_WIDTH    = 5,
  parameter int unsigned RES_ADDR_WIDTH = 8,
  parameter int unsigned HAZARD_DEPTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INSTR_WIDTH-1:0]    in_instr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OP_WIDTH-1:0]       out_op,
  output logic [REG_ADDR_WIDTH-1:0] out_src_a,
  output logic [REG_ADDR_WIDTH-1:0] out_src_b,
  output logic [REG_ADDR_WIDTH-1:0] out_src_c,
  output logic                      out_src_a_reg,
  output logic                      out_src_b_reg,
  output logic                      out_src_c_reg,
  output logic                      out_src_a_needed,
  output logic                      out_src_b_needed,
  output logic                      out_src_c_needed,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      out_saturate,
  output logic [SHIFT_WIDTH-1:0]    out_shift,
  output logic                      out_no_shift,
  output logic [RES_ADDR_WIDTH-1:0] out_res_addr,
  output logic                      stall
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  ,
  output logic                      illegal
`endif
);

  localparam int unsigned RA = REG_ADDR_WIDTH;

  // Field offsets, LSB first.
  localparam int unsigned OFF_OP   = 0;
  localparam int unsigned OFF_FMT  = OFF_OP + OP_WIDTH;
  localparam int unsigned OFF_A    = OFF_FMT + 1;
  localparam int unsigned OFF_B    = OFF_A + RA + 1;
  localparam int unsigned OFF_C    = OFF_B + RA + 1;
  localparam int unsigned OFF_D0   = OFF_C + RA + 1;
  localparam int unsigned OFF_SH   = OFF_D0 + RA;
  localparam int unsigned OFF_SATN = OFF_SH + SHIFT_WIDTH;
  localparam int unsigned OFF_D1   = OFF_C;
  localparam int unsigned OFF_RES  = OFF_D1 + RA;

`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  localparam logic [OP_WIDTH-1:0] NOP_OP = OP_WIDTH'(OP_NOP);
`endif

  typedef struct packed {
    logic [OP_WIDTH-1:0]       op;
    logic [RA-1:0]             src_a;
    logic [RA-1:0]             src_b;
    logic [RA-1:0]             src_c;
    logic                      src_a_reg;
    logic                      src_b_reg;
    logic                      src_c_reg;
    logic [2:0]                needed;     // {c, b, a}
    logic [RA-1:0]             dest;
    logic                      saturate;
    logic [SHIFT_WIDTH-1:0]    shift;
    logic                      no_shift;
    logic [RES_ADDR_WIDTH-1:0] res_addr;
    logic                      writes;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    logic                      illegal;
`endif
  } bundle_t;

  logic     w_fmt;
  bundle_t  w_dec;
  op_ext_t  w_op_ext;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  logic [2:0] w_needed_raw;
  logic       w_illegal;
`endif

  bundle_t  r_out;
  logic     r_out_valid;

  logic [2:0][RA-1:0] w_src;
  logic [2:0]         w_src_reg;
  logic [2:0]         w_chk;
  logic [2:0]         w_out_match;
  logic [2:0]         w_sb_match;
  logic               w_stall;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_issue;

  // Decode of the word currently on in_instr.
  always_comb begin
    w_dec           = '0;
    w_fmt           = in_instr[OFF_FMT];
    w_dec.op        = in_instr[OFF_OP +: OP_WIDTH];
    w_dec.src_a     = in_instr[OFF_A +: RA];
    w_dec.src_a_reg = in_instr[OFF_A + RA];
    w_dec.src_b     = in_instr[OFF_B +: RA];
    w_dec.src_b_reg = in_instr[OFF_B + RA];
    w_dec.no_shift  = in_instr[INSTR_WIDTH-1];
    if (!w_fmt) begin
      w_dec.src_c     = in_instr[OFF_C +: RA];
      w_dec.src_c_reg = in_instr[OFF_C + RA];
      w_dec.dest      = in_instr[OFF_D0 +: RA];
      w_dec.shift     = in_instr[OFF_SH +: SHIFT_WIDTH];
      w_dec.saturate  = ~in_instr[OFF_SATN];
      w_dec.res_addr  = '0;
    end else begin
      w_dec.src_c     = '0;
      w_dec.src_c_reg = 1'b0;
      w_dec.dest      = in_instr[OFF_D1 +: RA];
      w_dec.shift     = '0;
      w_dec.saturate  = 1'b1;
      w_dec.res_addr  = in_instr[OFF_RES +: RES_ADDR_WIDTH];
    end
    w_op_ext = op_ext_t'(w_dec.op);
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    // Classify on the raw opcode, then reclassify as NOP so an illegal word
    // neither stalls on its sources nor claims its destination.
    w_needed_raw = src_needed(w_op_ext);
    w_illegal    = !is_defined_op(w_op_ext) || (w_fmt && w_needed_raw[2]);
    if (w_illegal) begin
      w_dec.op = NOP_OP;
      w_op_ext = OP_NOP;
    end
    w_dec.illegal = w_illegal;
`endif
    w_dec.needed = src_needed(w_op_ext);
    w_dec.writes = writes_dest(w_op_ext);
  end

  // Hazard detection: only needed register sources are compared, against
  // the in-flight scoreboard and the bundle waiting in the output register.
  assign w_src     = {w_dec.src_c, w_dec.src_b, w_dec.src_a};
  assign w_src_reg = {w_dec.src_c_reg, w_dec.src_b_reg, w_dec.src_a_reg};
  assign w_chk     = w_dec.needed & w_src_reg;

  always_comb begin
    w_out_match = '0;
    for (int unsigned s = 0; s < 3; s++) begin
      w_out_match[s] = r_out_valid & r_out.writes & (w_src[s] == r_out.dest);
    end
  end

  assign w_stall    = in_valid & (|(w_chk & (w_sb_match | w_out_match)));
  assign w_in_ready = (~r_out_valid | out_ready) & ~w_stall;
  assign w_accept   = in_valid & w_in_ready;
  assign w_issue    = r_out_valid & out_ready & r_out.writes;

  hazard_scoreboard #(
    .HAZARD_DEPTH  (HAZARD_DEPTH),
    .REG_ADDR_WIDTH(RA)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_insert     (w_issue),
    .i_insert_addr(r_out.dest),
    .i_src_addr   (w_src),
    .i_src_check  (w_chk),
    .o_match      (w_sb_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready         = w_in_ready;
  assign stall            = w_stall;
  assign out_valid        = r_out_valid;
  assign out_op           = r_out.op;
  assign out_src_a        = r_out.src_a;
  assign out_src_b        = r_out.src_b;
  assign out_src_c        = r_out.src_c;
  assign out_src_a_reg    = r_out.src_a_reg;
  assign out_src_b_reg    = r_out.src_b_reg;
  assign out_src_c_reg    = r_out.src_c_reg;
  assign out_src_a_needed = r_out.needed[0];
  assign out_src_b_needed = r_out.needed[1];
  assign out_src_c_needed = r_out.needed[2];
  assign out_dest         = r_out.dest;
  assign out_saturate     = r_out.saturate;
  assign out_shift        = r_out.shift;
  assign out_no_shift     = r_out.no_shift;
  assign out_res_addr     = r_out.res_addr;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  assign illegal          = r_out.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  localparam logic [4:0] NOP  = 5'd0;
  localparam logic [4:0] LOAD = 5'd1;
  localparam logic [4:0] ADD  = 5'd8;
  localparam logic [4:0] SUB  = 5'd9;
  localparam logic [4:0] MUL  = 5'd10;
  localparam logic [4:0] MADD = 5'd11;
  localparam logic [4:0] MAC  = 5'd14;

  logic        clk;
  logic        reset;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_op;
  logic [3:0]  out_src_a, out_src_b, out_src_c;
  logic        out_src_a_reg, out_src_b_reg, out_src_c_reg;
  logic        out_src_a_needed, out_src_b_needed, out_src_c_needed;
  logic [3:0]  out_dest;
  logic        out_saturate;
  logic [4:0]  out_shift;
  logic        out_no_shift;
  logic [7:0]  out_res_addr;
  logic        stall;
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks;
  int errors;

  instr_decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_instr        (in_instr),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_op          (out_op),
    .out_src_a       (out_src_a),
    .out_src_b       (out_src_b),
    .out_src_c       (out_src_c),
    .out_src_a_reg   (out_src_a_reg),
    .out_src_b_reg   (out_src_b_reg),
    .out_src_c_reg   (out_src_c_reg),
    .out_src_a_needed(out_src_a_needed),
    .out_src_b_needed(out_src_b_needed),
    .out_src_c_needed(out_src_c_needed),
    .out_dest        (out_dest),
    .out_saturate    (out_saturate),
    .out_shift       (out_shift),
    .out_no_shift    (out_no_shift),
    .out_res_addr    (out_res_addr),
    .stall           (stall)
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    ,
    .illegal         (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Format 0: op, fmt=0, {a_reg,a}, {b_reg,b}, {c_reg,c}, dest, shift, sat_n, no_shift at bit 31.
  function automatic logic [31:0] f0(input logic [4:0] op, input logic ar, input logic [3:0] a,
                                     input logic br, input logic [3:0] b, input logic cr,
                                     input logic [3:0] c, input logic [3:0] d, input logic [4:0] sh,
                                     input logic satn, input logic ns);
    return {ns, satn, sh, d, cr, c, br, b, ar, a, 1'b0, op};
  endfunction

  // Format 1: op, fmt=1, {a_reg,a}, {b_reg,b}, dest, res_addr, unused, no_shift at bit 31.
  function automatic logic [31:0] f1(input logic [4:0] op, input logic ar, input logic [3:0] a,
                                     input logic br, input logic [3:0] b, input logic [3:0] d,
                                     input logic [7:0] res, input logic ns);
    return {ns, 3'b000, res, d, br, b, ar, a, 1'b1, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_op !== 5'd0) begin errors++; $display("FAIL reset_out_op got %0h exp 0", out_op); end
    checks++; if ({out_src_a, out_src_b, out_src_c, out_dest} !== 16'h0) begin errors++;
      $display("FAIL reset_addrs got %0h exp 0", {out_src_a, out_src_b, out_src_c, out_dest}); end
    checks++; if ({out_res_addr, out_shift, out_saturate} !== 14'h0) begin errors++;
      $display("FAIL reset_fields got %0h exp 0", {out_res_addr, out_shift, out_saturate}); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_fmt0();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(ADD, 1'b1, 4'd2, 1'b1, 4'd5, 1'b0, 4'd0, 4'd7, 5'd3, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fmt0_in_ready got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt0_valid got %0b exp 1", out_valid); end
    checks++; if (out_op !== ADD) begin errors++; $display("FAIL fmt0_op got %0h exp %0h", out_op, ADD); end
    checks++; if ({out_src_a, out_src_b, out_dest} !== 12'h257) begin errors++;
      $display("FAIL fmt0_addrs got %0h exp 257", {out_src_a, out_src_b, out_dest}); end
    checks++; if ({out_src_a_needed, out_src_b_needed, out_src_c_needed} !== 3'b110) begin errors++;
      $display("FAIL fmt0_needed got %b exp 110", {out_src_a_needed, out_src_b_needed, out_src_c_needed}); end
    checks++; if ({out_saturate, out_shift, out_no_shift} !== {1'b1, 5'd3, 1'b0}) begin errors++;
      $display("FAIL fmt0_sat_shift got %b exp 1000110", {out_saturate, out_shift, out_no_shift}); end
    checks++; if (out_res_addr !== 8'h00) begin errors++; $display("FAIL fmt0_res got %0h exp 0", out_res_addr); end
    idle(5);
  endtask

  task automatic test_fmt1();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f1(LOAD, 1'b1, 4'd3, 1'b0, 4'd9, 4'd4, 8'hA5, 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if (out_op !== LOAD) begin errors++; $display("FAIL fmt1_op got %0h exp %0h", out_op, LOAD); end
    checks++; if ({out_src_c, out_src_c_reg, out_shift} !== 10'h0) begin errors++;
      $display("FAIL fmt1_c_shift got %0h exp 0", {out_src_c, out_src_c_reg, out_shift}); end
    checks++; if ({out_saturate, out_no_shift, out_res_addr, out_dest} !== {1'b1, 1'b1, 8'hA5, 4'd4}) begin errors++;
      $display("FAIL fmt1_fields got %0h exp 3a54", {out_saturate, out_no_shift, out_res_addr, out_dest}); end
    checks++; if ({out_src_a_needed, out_src_b_needed, out_src_c_needed} !== 3'b000) begin errors++;
      $display("FAIL fmt1_needed got %b exp 000", {out_src_a_needed, out_src_b_needed, out_src_c_needed}); end
    idle(5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [3];
    logic [4:0]  e_op [3];
    logic [3:0]  e_d [3];
    logic [7:0]  e_res [3];
    logic [6:0]  e_misc [3];  // {saturate, shift, no_shift}
    v[0] = f0(MADD, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 4'd8, 5'd31, 1'b1, 1'b0);
    v[1] = f0(SUB, 1'b0, 4'd4, 1'b1, 4'd5, 1'b0, 4'd6, 4'd9, 5'd0, 1'b0, 1'b1);
    v[2] = f1(MUL, 1'b1, 4'd1, 1'b1, 4'd2, 4'd10, 8'h3C, 1'b0);
    e_op[0] = MADD; e_d[0] = 4'd8;  e_res[0] = 8'h00; e_misc[0] = {1'b0, 5'd31, 1'b0};
    e_op[1] = SUB;  e_d[1] = 4'd9;  e_res[1] = 8'h00; e_misc[1] = {1'b1, 5'd0, 1'b1};
    e_op[2] = MUL;  e_d[2] = 4'd10; e_res[2] = 8'h3C; e_misc[2] = {1'b1, 5'd0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = v[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %0b exp 1", i, in_ready); end
      step();
      checks++; if ({out_valid, out_op, out_dest, out_res_addr} !== {1'b1, e_op[i], e_d[i], e_res[i]}) begin errors++;
        $display("FAIL b2b_bundle[%0d] got %0h exp %0h", i, {out_valid, out_op, out_dest, out_res_addr},
                 {1'b1, e_op[i], e_d[i], e_res[i]}); end
      checks++; if ({out_saturate, out_shift, out_no_shift} !== e_misc[i]) begin errors++;
        $display("FAIL b2b_misc[%0d] got %b exp %b", i, {out_saturate, out_shift, out_no_shift}, e_misc[i]); end
    end
    checks++; if ({out_src_a_needed, out_src_b_needed, out_src_c_needed} !== 3'b110) begin errors++;
      $display("FAIL b2b_fmt1_mul_needed got %b exp 110", {out_src_a_needed, out_src_b_needed, out_src_c_needed}); end
    idle(5);
  endtask

  task automatic test_hazard();
    int n;
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(MUL, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd3, 5'd0, 1'b0, 1'b0);
    step();
    in_instr = f0(ADD, 1'b1, 4'd3, 1'b1, 4'd4, 1'b0, 4'd0, 4'd12, 5'd0, 1'b0, 1'b0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready[%0d] got %0b exp 0", n, in_ready); end
      step();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL hazard_stall_cycles got %0d exp 4", n); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_op, out_src_a} !== {1'b1, ADD, 4'd3}) begin errors++;
      $display("FAIL hazard_issue got %0h exp %0h", {out_valid, out_op, out_src_a}, {1'b1, ADD, 4'd3}); end
    idle(5);
    // Needed register source c on a producer still in flight.
    in_valid = 1'b1;
    in_instr = f0(MUL, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd3, 5'd0, 1'b0, 1'b0);
    step(); step();
    in_instr = f0(MADD, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd12, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_src_c got %0b exp 1", stall); end
    idle(5);
  endtask

  task automatic test_channel();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(MUL, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd3, 5'd0, 1'b0, 1'b0);
    step();
    in_instr = f0(ADD, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0, 4'd0, 4'd12, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({stall, in_ready} !== 2'b01) begin errors++;
      $display("FAIL channel_no_stall got %b exp 01", {stall, in_ready}); end
    step();
    checks++; if (out_op !== ADD) begin errors++; $display("FAIL channel_issue got %0h exp %0h", out_op, ADD); end
    // Register source that the op does not use must not stall either.
    in_instr = f1(LOAD, 1'b1, 4'd3, 1'b1, 4'd3, 4'd13, 8'h00, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unneeded_src_stall got %0b exp 0", stall); end
    step();
    idle(5);
  endtask

  task automatic test_hold();
    logic [31:0] v [10];
    logic [17:0] e [10];  // {op, dest, shift, src_a}
    int sent, got;
    logic acc, cons;
    logic [4:0] op;
    for (int i = 0; i < 10; i++) begin
      op = (i % 3 == 0) ? ADD : ((i % 3 == 1) ? SUB : MUL);
      v[i] = f0(op, 1'b0, 4'(i), 1'b0, 4'(i + 1), 1'b0, 4'd0, 4'(i), 5'(i), 1'(i), 1'b0);
      e[i] = {op, 4'(i), 5'(i), 4'(i)};
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 7);
      in_valid  = (sent < 10);
      in_instr  = (sent < 10) ? v[sent] : 32'h0;
      #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (got >= 10) begin errors++; $display("FAIL hold_duplicate got bundle %0h exp none", {out_op, out_dest}); end
        else if ({out_op, out_dest, out_shift, out_src_a} !== e[got]) begin errors++;
          $display("FAIL hold_bundle[%0d] got %0h exp %0h", got, {out_op, out_dest, out_shift, out_src_a}, e[got]); end
        if (out_ready == 1'b0) begin
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %0b exp 0", cyc, in_ready); end
        end
      end
      acc  = in_valid & in_ready;
      cons = out_valid & out_ready;
      step();
      if (acc)  sent++;
      if (cons) got++;
      if (got == 10) break;
    end
    checks++; if (got !== 10 || sent !== 10) begin errors++;
      $display("FAIL hold_count got %0d/%0d exp 10/10", got, sent); end
    out_ready = 1'b1;
    idle(5);
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(MUL, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd3, 5'd0, 1'b0, 1'b0);
    step();
    in_instr = f0(ADD, 1'b1, 4'd3, 1'b1, 4'd4, 1'b0, 4'd0, 4'd12, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_pre got %0b exp 1", stall); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, stall, in_ready} !== 3'b001) begin errors++;
      $display("FAIL rst_stall_post got %b exp 001", {out_valid, stall, in_ready}); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_op, out_dest} !== {1'b1, ADD, 4'd12}) begin errors++;
      $display("FAIL rst_stall_issue got %0h exp %0h", {out_valid, out_op, out_dest}, {1'b1, ADD, 4'd12}); end
    idle(5);
  endtask

`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(5'h1F, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6, 5'd0, 1'b0, 1'b0);
    step();
    checks++; if ({illegal, out_op} !== {1'b1, NOP}) begin errors++;
      $display("FAIL illegal_undef got %0h exp %0h", {illegal, out_op}, {1'b1, NOP}); end
    in_instr = f0(ADD, 1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 4'd0, 4'd11, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL illegal_reader_stall got %0b exp 0", stall); end
    step();
    checks++; if ({illegal, out_op} !== {1'b0, ADD}) begin errors++;
      $display("FAIL illegal_legal got %0h exp %0h", {illegal, out_op}, {1'b0, ADD}); end
    in_instr = f1(MAC, 1'b0, 4'd1, 1'b0, 4'd2, 4'd5, 8'h00, 1'b0);
    step();
    in_valid = 1'b0;
    checks++; if ({illegal, out_op} !== {1'b1, NOP}) begin errors++;
      $display("FAIL illegal_fmt1_c got %0h exp %0h", {illegal, out_op}, {1'b1, NOP}); end
    idle(5);
  endtask
`else
  task automatic test_undefined_op();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = f0(5'h1F, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0, 4'd0, 4'd6, 5'd0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_op} !== {1'b1, 5'h1F}) begin errors++;
      $display("FAIL undef_passthrough got %0h exp %0h", {out_valid, out_op}, {1'b1, 5'h1F}); end
    idle(5);
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_fmt0();
    test_fmt1();
    test_back_to_back();
    test_hazard();
    test_channel();
    test_hold();
    test_reset_stall();
`ifdef INSTR_DEC_ILLEGAL_TRAP_EN
    test_illegal();
`else
    test_undefined_op();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
